// File: rtl/quiz_fluxo_dados.sv
// quiz_fluxo_dados: datapath for the quiz game, driven by the control-unit FSM.
// Ports:
//   clock, reset            : clock and asynchronous active-high reset
//   zeraR..zeraL            : synchronous clears (R, E, S, M, timer, LED register)
//   registraR, registraM    : load play register / answer register (+ LED enable)
//   contaE, contaS, contaTMR: increment address counter / round counter / timer
//   botoes                  : raw one-hot player buttons (asynchronous)
//   jogada                  : one-cycle pulse on a new button press
//   igual                   : R == M
//   timeout, fimTMR         : timer reached answer-window / display limit
//   enderecoIgualSequencia  : E == S
//   fimE, fimS              : E / S at last round
//   leds                    : answer LEDs (M while L is set)
//   db_*                    : debug views of S, E, R, M
module quiz_fluxo_dados #(
  parameter int N_RODADAS = 16,
  parameter int T_MOSTRA  = 2000,
  parameter int T_JOGADA  = 5000,
  parameter int W_TMR     = 13,
  localparam int W_E      = $clog2(N_RODADAS)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           zeraR,
  input  logic           zeraE,
  input  logic           zeraS,
  input  logic           zeraM,
  input  logic           zeraTMR,
  input  logic           zeraL,
  input  logic           registraR,
  input  logic           registraM,
  input  logic           contaE,
  input  logic           contaS,
  input  logic           contaTMR,
  input  logic [3:0]     botoes,
  output logic           jogada,
  output logic           igual,
  output logic           timeout,
  output logic           enderecoIgualSequencia,
  output logic           fimE,
  output logic           fimS,
  output logic           fimTMR,
  output logic [3:0]     leds,
  output logic [W_E-1:0] db_rodada,
  output logic [W_E-1:0] db_endereco,
  output logic [3:0]     db_jogada,
  output logic [3:0]     db_resposta
);

  localparam logic [W_E-1:0]   E_LAST  = W_E'(N_RODADAS - 1);
  localparam logic [W_TMR-1:0] TMR_MOS = W_TMR'(T_MOSTRA);
  localparam logic [W_TMR-1:0] TMR_JOG = W_TMR'(T_JOGADA);

  logic [W_E-1:0]   e_cnt;
  logic [W_E-1:0]   s_cnt;
  logic [3:0]       r_reg;
  logic [3:0]       m_reg;
  logic             l_reg;
  logic [W_TMR-1:0] tmr;
  logic [3:0]       sync1;
  logic [3:0]       botoes_sync;
  logic             any_d;
  logic             any;

  // Answer ROM: question i expects button (i mod 4), one-hot.
  function automatic logic [3:0] rom_answer(input logic [W_E-1:0] idx);
    logic [1:0] sel;
    sel = idx[1:0];
    return 4'b0001 << sel;
  endfunction

  // Modulo-N_RODADAS increment; explicit compare keeps it correct for non-power-of-2 N.
  function automatic logic [W_E-1:0] inc_mod(input logic [W_E-1:0] v);
    return (v == E_LAST) ? {W_E{1'b0}} : v + W_E'(1);
  endfunction

  // Address and round counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_cnt <= '0;
      s_cnt <= '0;
    end else begin
      if (zeraE)       e_cnt <= '0;
      else if (contaE) e_cnt <= inc_mod(e_cnt);
      if (zeraS)       s_cnt <= '0;
      else if (contaS) s_cnt <= inc_mod(s_cnt);
    end
  end

  // Display/answer timer; saturates at T_JOGADA so timeout stays up until cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr <= '0;
    end else if (zeraTMR) begin
      tmr <= '0;
    end else if (contaTMR && (tmr != TMR_JOG)) begin
      tmr <= tmr + W_TMR'(1);
    end
  end

  // Answer, play and LED-enable registers; clears win over loads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg <= 4'b0000;
      m_reg <= 4'b0000;
      l_reg <= 1'b0;
    end else begin
      if (zeraR)          r_reg <= 4'b0000;
      else if (registraR) r_reg <= botoes_sync;
      if (zeraM)          m_reg <= 4'b0000;
      else if (registraM) m_reg <= rom_answer(s_cnt);
      if (zeraL || zeraM) l_reg <= 1'b0;
      else if (registraM) l_reg <= 1'b1;
    end
  end

  // Two-flop synchronizer on the raw buttons plus the edge-detect flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1       <= 4'b0000;
      botoes_sync <= 4'b0000;
      any_d       <= 1'b0;
    end else begin
      sync1       <= botoes;
      botoes_sync <= sync1;
      any_d       <= any;
    end
  end

  assign any                    = |botoes_sync;
  assign jogada                 = any & ~any_d;
  assign igual                  = (r_reg == m_reg);
  assign enderecoIgualSequencia = (e_cnt == s_cnt);
  assign fimE                   = (e_cnt == E_LAST);
  assign fimS                   = (s_cnt == E_LAST);
  assign fimTMR                 = (tmr == TMR_MOS);
  assign timeout                = (tmr == TMR_JOG);
  assign leds                   = l_reg ? m_reg : 4'b0000;
  assign db_rodada              = s_cnt;
  assign db_endereco            = e_cnt;
  assign db_jogada              = r_reg;
  assign db_resposta            = m_reg;

endmodule

// File: tb/tb_quiz_fluxo_dados.sv
module tb_quiz_fluxo_dados;

  localparam int N  = 16;
  localparam int TM = 2000;
  localparam int TJ = 5000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic zeraR = 1'b0, zeraE = 1'b0, zeraS = 1'b0, zeraM = 1'b0, zeraTMR = 1'b0, zeraL = 1'b0;
  logic registraR = 1'b0, registraM = 1'b0;
  logic contaE = 1'b0, contaS = 1'b0, contaTMR = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic jogada, igual, timeout, enderecoIgualSequencia, fimE, fimS, fimTMR;
  logic [3:0] leds, db_rodada, db_endereco, db_jogada, db_resposta;

  int n_tests = 0;
  int n_fail  = 0;
  logic started = 1'b0;

  quiz_fluxo_dados dut (
    .clock(clock), .reset(reset),
    .zeraR(zeraR), .zeraE(zeraE), .zeraS(zeraS), .zeraM(zeraM),
    .zeraTMR(zeraTMR), .zeraL(zeraL),
    .registraR(registraR), .registraM(registraM),
    .contaE(contaE), .contaS(contaS), .contaTMR(contaTMR),
    .botoes(botoes),
    .jogada(jogada), .igual(igual), .timeout(timeout),
    .enderecoIgualSequencia(enderecoIgualSequencia),
    .fimE(fimE), .fimS(fimS), .fimTMR(fimTMR), .leds(leds),
    .db_rodada(db_rodada), .db_endereco(db_endereco),
    .db_jogada(db_jogada), .db_resposta(db_resposta)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  int         e_m, s_m, tmr_m;
  logic [3:0] r_m, m_m;
  logic       l_m;
  logic [3:0] hist [0:2];   // button samples at the last three edges, newest first

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      e_m <= 0; s_m <= 0; tmr_m <= 0;
      r_m <= 4'b0000; m_m <= 4'b0000; l_m <= 1'b0;
      hist[0] <= 4'b0000; hist[1] <= 4'b0000; hist[2] <= 4'b0000;
    end else begin
      e_m   <= zeraE ? 0 : (contaE ? (e_m + 1) % N : e_m);
      s_m   <= zeraS ? 0 : (contaS ? (s_m + 1) % N : s_m);
      tmr_m <= zeraTMR ? 0 : ((contaTMR && tmr_m < TJ) ? tmr_m + 1 : tmr_m);
      r_m   <= zeraR ? 4'b0000 : (registraR ? hist[1] : r_m);
      m_m   <= zeraM ? 4'b0000 : (registraM ? 4'((1 << (s_m % 4))) : m_m);
      l_m   <= (zeraL || zeraM) ? 1'b0 : (registraM ? 1'b1 : l_m);
      hist[0] <= botoes;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  function automatic logic [26:0] model_vec();
    logic [26:0] v;
    v = {(|hist[1]) & ~(|hist[2]),
         r_m == m_m,
         tmr_m == TJ,
         e_m == s_m,
         e_m == N - 1,
         s_m == N - 1,
         tmr_m == TM,
         l_m ? m_m : 4'b0000,
         4'(s_m), 4'(e_m), r_m, m_m};
    return v;
  endfunction

  function automatic logic [26:0] dut_vec();
    return {jogada, igual, timeout, enderecoIgualSequencia, fimE, fimS, fimTMR,
            leds, db_rodada, db_endereco, db_jogada, db_resposta};
  endfunction

  // Per-cycle compare of every output against the model, just after each edge.
  always @(posedge clock) begin
    #1;
    if (started) begin
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, dut_vec(), model_vec());
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press a button vector for 10 cycles, expect one pulse 2 edges after the
  // press, then load R and check it along with the resulting igual.
  task automatic press(input logic [3:0] v, input logic exp_igual, input string tag);
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    botoes = v;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (jogada) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_pulse_cycle"}, first, 2);
    registraR = 1'b1;
    cyc(1);
    registraR = 1'b0;
    check({tag, "_db_jogada"}, db_jogada, v);
    check({tag, "_igual"}, igual, exp_igual);
    botoes = 4'b0000;
    cyc(4);
  endtask

  initial begin
    int fim_cnt, fim_at, to_first;
    logic to_held;

    #1 reset = 1'b1;
    started = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    check("rst_leds", leds, 4'b0000);
    check("rst_igual", igual, 1'b1);
    check("rst_eq_seq", enderecoIgualSequencia, 1'b1);
    check("rst_jogada", jogada, 1'b0);
    check("rst_fims", {fimE, fimS, fimTMR, timeout}, 4'b0000);

    // Round 3 answer is button 3.
    contaS = 1'b1; cyc(3); contaS = 1'b0;
    registraM = 1'b1; cyc(1); registraM = 1'b0;
    check("rom_s3_resp", db_resposta, 4'b1000);
    check("rom_s3_leds", leds, 4'b1000);
    zeraL = 1'b1; cyc(1); zeraL = 1'b0;
    check("zeraL_leds", leds, 4'b0000);
    check("zeraL_m_kept", db_resposta, 4'b1000);

    press(4'b1000, 1'b1, "press_b3");
    press(4'b0100, 1'b0, "press_b2");
    press(4'b1100, 1'b0, "press_two");

    // Timer: fimTMR only at count 2000, timeout from 5000 and held.
    zeraTMR = 1'b1; cyc(1); zeraTMR = 1'b0;
    contaTMR = 1'b1;
    fim_cnt = 0; fim_at = -1; to_first = -1; to_held = 1'b1;
    for (int i = 1; i <= 5010; i++) begin
      cyc(1);
      if (fimTMR) begin fim_cnt++; fim_at = i; end
      if (timeout && to_first < 0) to_first = i;
      if (to_first >= 0 && !timeout) to_held = 1'b0;
    end
    check("fimTMR_count", fim_cnt, 1);
    check("fimTMR_at", fim_at, TM);
    check("timeout_at", to_first, TJ);
    check("timeout_held", to_held, 1'b1);
    zeraTMR = 1'b1; cyc(1); zeraTMR = 1'b0; contaTMR = 1'b0;
    check("zeraTMR_clear", {fimTMR, timeout}, 2'b00);

    // Counters to the last round, then wrap S and clear E over contaE.
    zeraE = 1'b1; zeraS = 1'b1; cyc(1); zeraE = 1'b0; zeraS = 1'b0;
    contaE = 1'b1; contaS = 1'b1; cyc(15); contaE = 1'b0; contaS = 1'b0;
    check("last_fims", {fimE, fimS}, 2'b11);
    check("last_eq", enderecoIgualSequencia, 1'b1);
    check("last_s", db_rodada, 4'd15);
    contaS = 1'b1; cyc(1); contaS = 1'b0;
    check("wrap_s", db_rodada, 4'd0);
    check("wrap_fimS", fimS, 1'b0);
    check("wrap_eq", enderecoIgualSequencia, 1'b0);
    contaE = 1'b1; zeraE = 1'b1; cyc(1); contaE = 1'b0; zeraE = 1'b0;
    check("zera_over_conta", db_endereco, 4'd0);

    // Reset one cycle into a press: everything clears at once, no pulse.
    contaS = 1'b1; registraM = 1'b1; cyc(1); contaS = 1'b0; registraM = 1'b0;
    botoes = 4'b0010;
    cyc(1);
    reset = 1'b1;
    #1;
    check("midrst_regs", {db_rodada, db_endereco, db_jogada, db_resposta, leds}, 20'h0);
    check("midrst_jogada", jogada, 1'b0);
    botoes = 4'b0000;
    cyc(1);
    reset = 1'b0;
    fim_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (jogada) fim_cnt++;
    end
    check("midrst_no_pulse", fim_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
